// File: rtl/pwm_pkg.sv
// Shared register map and small types for the PWM array controller.
package pwm_pkg;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PER_LO   = 3'd1;
  localparam logic [2:0] OFF_PER_HI   = 3'd2;
  localparam logic [2:0] OFF_DUTY_LO  = 3'd3;
  localparam logic [2:0] OFF_DUTY_HI  = 3'd4;
  localparam logic [2:0] OFF_DEADTIME = 3'd5;
  localparam logic [2:0] OFF_STATUS   = 3'd6;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_BIT = 1;
  localparam int CTRL_INV_BIT  = 2;

  localparam int STATUS_PENDING_BIT = 0;
  localparam int STATUS_WRAP_BIT    = 1;

  localparam logic [5:0] GCTRL_ADDR     = 6'h38;
  localparam int         GCTRL_SYNC_BIT = 0;

  typedef enum logic {MODE_EDGE = 1'b0, MODE_CENTER = 1'b1} pwm_mode_e;
  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} count_dir_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active registers, edge or center counter,
// duty compare and dead-time insertion with registered outputs.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int DT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             inv,
  input  logic             sync,
  input  logic             per_lo_wr,
  input  logic             per_hi_wr,
  input  logic             duty_lo_wr,
  input  logic             duty_hi_wr,
  input  logic             dt_wr,
  input  logic             wrap_clr,
  input  logic [7:0]       wr_data,
  output logic [CNT_W-1:0] shadow_per,
  output logic [CNT_W-1:0] shadow_duty,
  output logic [DT_W-1:0]  shadow_dt,
  output logic             pending,
  output logic             wrap,
  output logic             pwm_a,
  output logic             pwm_b
);

  logic [CNT_W-1:0] active_per, active_duty, cnt, cnt_next, per_m1;
  logic [CNT_W-1:0] per_next, duty_next;
  logic [DT_W-1:0]  active_dt, dt_next, run, run_now;
  logic [15:0]      per_ext, duty_ext;
  count_dir_e       dir, dir_next;
  pwm_mode_e        mode_e;
  logic             force_load, boundary, load, shadow_wr;
  logic             raw, prev_raw, a_val, b_val;

  assign mode_e = pwm_mode_e'(mode);

  // Byte-wide host writes land in a 16-bit view; bits at or above CNT_W drop.
  always_comb begin
    per_ext  = 16'(shadow_per);
    duty_ext = 16'(shadow_duty);
    if (per_lo_wr)  per_ext[7:0]   = wr_data;
    if (per_hi_wr)  per_ext[15:8]  = wr_data;
    if (duty_lo_wr) duty_ext[7:0]  = wr_data;
    if (duty_hi_wr) duty_ext[15:8] = wr_data;
    per_next  = per_ext[CNT_W-1:0];
    duty_next = duty_ext[CNT_W-1:0];
    dt_next   = dt_wr ? wr_data[DT_W-1:0] : shadow_dt;
    shadow_wr = per_lo_wr | per_hi_wr | duty_lo_wr | duty_hi_wr | dt_wr;
  end

  assign per_m1   = active_per - 1'b1;
  assign boundary = en && (cnt == '0) && (dir == DIR_UP);
  assign load     = !en || boundary || force_load;

  // Center mode holds each end value for two cycles by flipping direction
  // without moving the count.
  always_comb begin
    cnt_next = cnt;
    dir_next = dir;
    if (sync || !en || (active_per == '0)) begin
      cnt_next = '0;
      dir_next = DIR_UP;
    end else if (mode_e == MODE_EDGE) begin
      dir_next = DIR_UP;
      cnt_next = (cnt >= per_m1) ? '0 : cnt + 1'b1;
    end else if (dir == DIR_UP) begin
      if (cnt >= per_m1) begin
        cnt_next = per_m1;
        dir_next = DIR_DOWN;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end else begin
      if (cnt == '0) dir_next = DIR_UP;
      else           cnt_next = cnt - 1'b1;
    end
  end

  // run_now counts earlier consecutive cycles with the same raw level,
  // so an output may assert once raw has been steady for DT+1 cycles.
  always_comb begin
    raw = en && (active_per != '0) && (cnt < active_duty);
    if (raw != prev_raw) run_now = '0;
    else if (run == '1)  run_now = run;
    else                 run_now = run + 1'b1;
    a_val = raw && (run_now >= active_dt);
    b_val = !raw && (run_now >= active_dt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_per  <= '0;
      shadow_duty <= '0;
      shadow_dt   <= '0;
      active_per  <= '0;
      active_duty <= '0;
      active_dt   <= '0;
      pending     <= 1'b0;
      wrap        <= 1'b0;
      force_load  <= 1'b0;
      cnt         <= '0;
      dir         <= DIR_UP;
      prev_raw    <= 1'b0;
      run         <= '0;
      pwm_a       <= 1'b0;
      pwm_b       <= 1'b0;
    end else begin
      shadow_per  <= per_next;
      shadow_duty <= duty_next;
      shadow_dt   <= dt_next;
      if (load) begin
        active_per  <= shadow_per;
        active_duty <= shadow_duty;
        active_dt   <= shadow_dt;
      end
      if (shadow_wr)     pending <= 1'b1;
      else if (load)     pending <= 1'b0;
      if (boundary)      wrap <= 1'b1;
      else if (wrap_clr) wrap <= 1'b0;
      force_load <= sync;
      cnt        <= cnt_next;
      dir        <= dir_next;
      prev_raw   <= raw;
      run        <= run_now;
      pwm_a      <= en && (a_val ^ inv);
      pwm_b      <= en && (b_val ^ inv);
    end
  end

endmodule

// File: rtl/pwm_array_ctrl.sv
// Register-mapped array of PWM channels with a global sync strobe.
// Channel n lives at n*8+offset; GCTRL sits at 0x38.
module pwm_array_ctrl
  import pwm_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 8,
  parameter int DT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_write_en,
  input  logic [5:0]        i_address,
  input  logic [7:0]        i_data,
  output logic [7:0]        o_data,
  output logic [NUM_CH-1:0] o_pwm_a,
  output logic [NUM_CH-1:0] o_pwm_b
);

  logic [2:0]              ch_sel, off_sel;
  logic                    sync;
  logic [NUM_CH-1:0][7:0]  ch_rd;
  logic [7:0]              rd_next;

  assign ch_sel  = i_address[5:3];
  assign off_sel = i_address[2:0];
  assign sync    = i_write_en && (i_address == GCTRL_ADDR) && i_data[GCTRL_SYNC_BIT];

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic             hit;
    logic [2:0]       ctrl;
    logic [CNT_W-1:0] sh_per, sh_duty;
    logic [DT_W-1:0]  sh_dt;
    logic             pending, wrap;
    logic [15:0]      per_ext, duty_ext;
    logic [7:0]       rd;

    assign hit = i_write_en && (ch_sel == 3'(n));

    always_ff @(posedge clk) begin
      if (rst)                               ctrl <= '0;
      else if (hit && (off_sel == OFF_CTRL)) ctrl <= i_data[2:0];
    end

    pwm_channel #(
      .CNT_W(CNT_W),
      .DT_W (DT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en         (ctrl[CTRL_EN_BIT]),
      .mode       (ctrl[CTRL_MODE_BIT]),
      .inv        (ctrl[CTRL_INV_BIT]),
      .sync       (sync),
      .per_lo_wr  (hit && (off_sel == OFF_PER_LO)),
      .per_hi_wr  (hit && (off_sel == OFF_PER_HI)),
      .duty_lo_wr (hit && (off_sel == OFF_DUTY_LO)),
      .duty_hi_wr (hit && (off_sel == OFF_DUTY_HI)),
      .dt_wr      (hit && (off_sel == OFF_DEADTIME)),
      .wrap_clr   (hit && (off_sel == OFF_STATUS) && i_data[STATUS_WRAP_BIT]),
      .wr_data    (i_data),
      .shadow_per (sh_per),
      .shadow_duty(sh_duty),
      .shadow_dt  (sh_dt),
      .pending    (pending),
      .wrap       (wrap),
      .pwm_a      (o_pwm_a[n]),
      .pwm_b      (o_pwm_b[n])
    );

    assign per_ext  = 16'(sh_per);
    assign duty_ext = 16'(sh_duty);

    always_comb begin
      rd = '0;
      case (off_sel)
        OFF_CTRL:     rd = {5'b0, ctrl};
        OFF_PER_LO:   rd = per_ext[7:0];
        OFF_PER_HI:   rd = per_ext[15:8];
        OFF_DUTY_LO:  rd = duty_ext[7:0];
        OFF_DUTY_HI:  rd = duty_ext[15:8];
        OFF_DEADTIME: rd = 8'(sh_dt);
        OFF_STATUS: begin
          rd[STATUS_WRAP_BIT]    = wrap;
          rd[STATUS_PENDING_BIT] = pending;
        end
        default:      rd = '0;
      endcase
    end

    assign ch_rd[n] = rd;
  end

  // GCTRL and unpopulated channels never match a channel index, so read 0.
  always_comb begin
    rd_next = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (ch_sel == 3'(n)) rd_next = ch_rd[n];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) o_data <= '0;
    else     o_data <= rd_next;
  end

endmodule

// File: tb/tb_pwm_array_ctrl.sv
// Directed self-checking bench for pwm_array_ctrl (default parameters).
module tb_pwm_array_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_write_en;
  logic [5:0] i_address;
  logic [7:0] i_data;
  logic [7:0] o_data;
  logic [2:0] o_pwm_a;
  logic [2:0] o_pwm_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pwm_array_ctrl #(
    .NUM_CH(3),
    .CNT_W (8),
    .DT_W  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_write_en(i_write_en),
    .i_address (i_address),
    .i_data    (i_data),
    .o_data    (o_data),
    .o_pwm_a   (o_pwm_a),
    .o_pwm_b   (o_pwm_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge; the write is taken on the next rising edge.
  task automatic applyStimulus(input logic [5:0] addr, input logic [7:0] data);
    i_write_en = 1'b1;
    i_address  = addr;
    i_data     = data;
    @(negedge clk);
    i_write_en = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [5:0] addr, input logic [7:0] expected);
    i_address = addr;
    @(negedge clk);
    checkOutput(tag, 32'(o_data), 32'(expected));
  endtask

  task automatic pwmCheck(input string tag, input logic [2:0] exp_a, input logic [2:0] exp_b);
    checkOutput(tag, {26'b0, o_pwm_a, o_pwm_b}, {26'b0, exp_a, exp_b});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic xa, xb;
    int   ph;

    rst        = 1'b1;
    i_write_en = 1'b0;
    i_address  = '0;
    i_data     = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_outputs", 32'({o_data, o_pwm_a, o_pwm_b}), 32'h0);
    rst = 1'b0;

    $display("[TB] register map checks");
    readCheck("rst_ctrl0", 6'h00, 8'h00);
    readCheck("rst_status0", 6'h06, 8'h00);
    applyStimulus(6'h01, 8'd10);
    applyStimulus(6'h02, 8'hAB);
    readCheck("per_lo", 6'h01, 8'd10);
    readCheck("per_hi_masked", 6'h02, 8'h00);
    readCheck("pending_clear_en0", 6'h06, 8'h00);
    applyStimulus(6'h03, 8'd3);
    readCheck("duty_lo", 6'h03, 8'd3);
    applyStimulus(6'h18, 8'h01);
    readCheck("ch3_ignored", 6'h18, 8'h00);
    applyStimulus(6'h07, 8'hFF);
    readCheck("offset7", 6'h07, 8'h00);
    applyStimulus(6'h10, 8'hF8);
    readCheck("ctrl_high_bits", 6'h10, 8'h00);
    applyStimulus(6'h38, 8'h01);
    readCheck("gctrl_reads0", 6'h38, 8'h00);

    $display("[TB] ch2 PER=0 and WRAP handling");
    applyStimulus(6'h10, 8'h01);
    @(negedge clk);
    readCheck("wrap_set", 6'h16, 8'h02);
    pwmCheck("per0_raw_low", 3'b000, 3'b100);
    applyStimulus(6'h16, 8'h02);
    readCheck("wrap_set_priority", 6'h16, 8'h02);
    applyStimulus(6'h10, 8'h00);
    applyStimulus(6'h16, 8'h02);
    readCheck("wrap_cleared", 6'h16, 8'h00);

    $display("[TB] edge PER=10 DUTY=3 DT=0");
    applyStimulus(6'h00, 8'h01);
    for (int i = 0; i < 21; i++) begin
      ph = (i + 9) % 10;
      xa = (i > 0) && (ph < 3);
      xb = (i > 0) && !xa;
      pwmCheck($sformatf("edge_d3[%0d]", i), {2'b0, xa}, {2'b0, xb});
      @(negedge clk);
    end

    $display("[TB] edge PER=10 DUTY=5 DT=2");
    applyStimulus(6'h00, 8'h00);
    applyStimulus(6'h03, 8'd5);
    applyStimulus(6'h05, 8'd2);
    readCheck("dt_readback", 6'h05, 8'd2);
    applyStimulus(6'h00, 8'h01);
    for (int i = 0; i < 21; i++) begin
      ph = (i + 9) % 10;
      xa = (i > 0) && (ph >= 2) && (ph <= 4);
      xb = (i > 0) && (ph >= 7);
      pwmCheck($sformatf("deadtime[%0d]", i), {2'b0, xa}, {2'b0, xb});
      @(negedge clk);
    end

    $display("[TB] center PER=4 DUTY=2");
    applyStimulus(6'h00, 8'h00);
    applyStimulus(6'h01, 8'd4);
    applyStimulus(6'h03, 8'd2);
    applyStimulus(6'h05, 8'd0);
    applyStimulus(6'h00, 8'h03);
    for (int i = 0; i < 17; i++) begin
      ph = (i + 7) % 8;
      xa = (i > 0) && ((ph < 2) || (ph >= 6));
      xb = (i > 0) && !xa;
      pwmCheck($sformatf("center[%0d]", i), {2'b0, xa}, {2'b0, xb});
      @(negedge clk);
    end

    $display("[TB] shadow update DUTY 3->7 mid-period");
    applyStimulus(6'h00, 8'h00);
    applyStimulus(6'h01, 8'd10);
    applyStimulus(6'h03, 8'd3);
    applyStimulus(6'h00, 8'h01);
    for (int i = 0; i < 21; i++) begin
      ph = (i + 9) % 10;
      xa = (i > 0) && (ph < ((i >= 11) ? 7 : 3));
      xb = (i > 0) && !xa;
      pwmCheck($sformatf("shadow_pwm[%0d]", i), {2'b0, xa}, {2'b0, xb});
      if (i >= 7)
        checkOutput($sformatf("pending[%0d]", i), 32'(o_data[0]), 32'((i <= 11) ? 1 : 0));
      if (i == 5) begin
        i_write_en = 1'b1;
        i_address  = 6'h03;
        i_data     = 8'd7;
      end else begin
        i_write_en = 1'b0;
        i_address  = 6'h06;
      end
      @(negedge clk);
    end

    $display("[TB] GCTRL sync of ch0 and ch1");
    applyStimulus(6'h09, 8'd10);
    applyStimulus(6'h0B, 8'd7);
    applyStimulus(6'h08, 8'h01);
    repeat (3) @(negedge clk);
    applyStimulus(6'h38, 8'h01);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      ph = (i + 9) % 10;
      xa = (ph < 7);
      pwmCheck($sformatf("sync[%0d]", i), {1'b0, xa, xa}, {1'b0, !xa, !xa});
    end

    $display("[TB] INV then reset mid-pulse");
    applyStimulus(6'h00, 8'h05);
    applyStimulus(6'h38, 8'h01);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      pwmCheck($sformatf("inv[%0d]", i), 3'b010, 3'b001);
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_pulse", 32'({o_data, o_pwm_a, o_pwm_b}), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pwmCheck($sformatf("no_partial_pulse[%0d]", i), 3'b000, 3'b000);
    end
    readCheck("post_rst_ctrl0", 6'h00, 8'h00);
    readCheck("post_rst_per0", 6'h01, 8'h00);
    readCheck("post_rst_duty0", 6'h03, 8'h00);
    readCheck("post_rst_dt0", 6'h05, 8'h00);
    readCheck("post_rst_status0", 6'h06, 8'h00);
    readCheck("post_rst_ctrl1", 6'h08, 8'h00);
    readCheck("post_rst_per1", 6'h09, 8'h00);
    readCheck("post_rst_status1", 6'h0E, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
